// File: rtl/bmp_load_ctrl.sv
// bmp_load_ctrl
//   Streams a BMP file byte-by-byte from a registered ROM into a RAM, parsing
//   the BMP header as it passes and optionally inverting pixel bytes.
//
//   Optional feature macro: BMP_CHECKSUM_EN
//     defined   -> adds output checksum[15:0], mod-2^16 sum of every written byte,
//                  cleared on start, valid from the done pulse until next start.
//     undefined -> no checksum port and no adder.
//
// Ports
//   clk, rst          clock (rising edge), async active-high reset
//   start, mode       copy request pulse; mode 1 = invert pixel bytes (latched on start)
//   rom_valid/addr/q  ROM read port; rom_q returns one cycle after rom_valid
//   ram_valid/addr/d  RAM write port; ram_addr = ROM index + RAM_BASE (wraps)
//   busy, done        busy from cycle after start through the done cycle
//   err_sig, err_size sticky header error flags
//   hdr_offset/width/height  parsed little-endian header fields
module bmp_load_ctrl #(
  parameter int          BYTE_WIDTH = 8,
  parameter int          ADDR_WIDTH = 20,
  parameter int          TOTAL_SIZE = 786486,
  parameter int unsigned RAM_BASE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic                  rom_valid,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [BYTE_WIDTH-1:0] rom_q,
  output logic                  ram_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BYTE_WIDTH-1:0] ram_d,
  output logic                  busy,
  output logic                  done,
  output logic                  err_sig,
  output logic                  err_size,
`ifdef BMP_CHECKSUM_EN
  output logic [15:0]           checksum,
`endif
  output logic [31:0]           hdr_offset,
  output logic [31:0]           hdr_width,
  output logic [31:0]           hdr_height
);

  if (TOTAL_SIZE < 26) begin : g_size_chk
    $error("bmp_load_ctrl: TOTAL_SIZE must be >= 26 to hold the BMP header fields");
  end
  if (BYTE_WIDTH < 8) begin : g_byte_chk
    $error("bmp_load_ctrl: BYTE_WIDTH must be >= 8");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(RAM_BASE);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;     // next ROM address to issue
  logic                  mode_q, mode_d;
  logic                  rd_vld_q, rd_vld_d; // a ROM byte returns this cycle
  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d; // index of the returning byte
  logic                  err_sig_q, err_sig_d;
  logic                  err_size_q, err_size_d;
  logic [23:0]           size_q, size_d;     // low three bytes of the file-size field
  logic [31:0]           off_q, off_d;
  logic [31:0]           wid_q, wid_d;
  logic [31:0]           hgt_q, hgt_d;
`ifdef BMP_CHECKSUM_EN
  logic [15:0]           cks_q, cks_d;
`endif

  logic [31:0] idx32;
  logic [7:0]  hb;
  logic [1:0]  lane;
  logic        sig_bad;
  logic        inv;

  assign idx32 = 32'(rd_idx_q);
  assign hb    = rom_q[7:0];
  // Every 4-byte header field starts at an index == 2 mod 4, so one lane
  // selector serves offset, width and height.
  assign lane  = 2'(rd_idx_q[1:0] - 2'd2);

  always_comb begin
    sig_bad = 1'b0;
    if (rd_vld_q) begin
      if (idx32 == 32'd0 && hb != 8'h42) sig_bad = 1'b1;
      if (idx32 == 32'd1 && hb != 8'h4D) sig_bad = 1'b1;
    end
  end

  // Header bytes are protected twice: index >= 54 and index >= parsed offset.
  assign inv = mode_q && (idx32 >= 32'd54) && (idx32 >= off_q);

  assign rom_valid  = (state_q == S_READ);
  assign rom_addr   = addr_q;
  assign ram_valid  = rd_vld_q && !sig_bad;
  assign ram_addr   = rd_vld_q ? ADDR_WIDTH'(rd_idx_q + BASE) : '0;
  assign ram_d      = !rd_vld_q ? '0 : (inv ? ~rom_q : rom_q);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) || (state_q == S_ERR);
  assign err_sig    = err_sig_q;
  assign err_size   = err_size_q;
  assign hdr_offset = off_q;
  assign hdr_width  = wid_q;
  assign hdr_height = hgt_q;
`ifdef BMP_CHECKSUM_EN
  assign checksum   = cks_q;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    rd_vld_d   = 1'b0;
    rd_idx_d   = addr_q;
    err_sig_d  = err_sig_q;
    err_size_d = err_size_q;
    size_d     = size_q;
    off_d      = off_q;
    wid_d      = wid_q;
    hgt_d      = hgt_q;
`ifdef BMP_CHECKSUM_EN
    cks_d      = cks_q;
    if (ram_valid) cks_d = cks_q + 16'(ram_d);
`endif

    // Fields fill in as their bytes come back from the ROM.
    if (rd_vld_q && !sig_bad) begin
      if (idx32 >= 32'd2 && idx32 <= 32'd4) begin
        case (rd_idx_q[1:0])
          2'd2:    size_d[7:0]   = hb;
          2'd3:    size_d[15:8]  = hb;
          2'd0:    size_d[23:16] = hb;
          default: ;
        endcase
      end
      // Compare only once the top byte arrives, on the complete field.
      if (idx32 == 32'd5 && {hb, size_q} != 32'(TOTAL_SIZE)) err_size_d = 1'b1;
      if (idx32 >= 32'd10 && idx32 <= 32'd13) off_d[{lane, 3'b000} +: 8] = hb;
      if (idx32 >= 32'd18 && idx32 <= 32'd21) wid_d[{lane, 3'b000} +: 8] = hb;
      if (idx32 >= 32'd22 && idx32 <= 32'd25) hgt_d[{lane, 3'b000} +: 8] = hb;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_READ;
          addr_d     = '0;
          mode_d     = mode;
          err_sig_d  = 1'b0;
          err_size_d = 1'b0;
          size_d     = '0;
          off_d      = 32'hFFFF_FFFF; // no inversion until the real offset lands
          wid_d      = '0;
          hgt_d      = '0;
`ifdef BMP_CHECKSUM_EN
          cks_d      = '0;
`endif
        end
      end
      S_READ: begin
        // A bad signature kills the read issued this cycle as well.
        rd_vld_d = !sig_bad;
        if (sig_bad) begin
          state_d   = S_ERR;
          err_sig_d = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      mode_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
      err_sig_q  <= 1'b0;
      err_size_q <= 1'b0;
      size_q     <= '0;
      off_q      <= 32'hFFFF_FFFF;
      wid_q      <= '0;
      hgt_q      <= '0;
`ifdef BMP_CHECKSUM_EN
      cks_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
      err_sig_q  <= err_sig_d;
      err_size_q <= err_size_d;
      size_q     <= size_d;
      off_q      <= off_d;
      wid_q      <= wid_d;
      hgt_q      <= hgt_d;
`ifdef BMP_CHECKSUM_EN
      cks_q      <= cks_d;
`endif
    end
  end

endmodule

// File: tb/tb_bmp_load_ctrl.sv
module tb_bmp_load_ctrl;
  localparam int          N    = 62;
  localparam int          AW   = 20;
  localparam int unsigned BASE = 32'h000F_FFF0;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic          rom_valid, ram_valid, busy, done, err_sig, err_size;
  logic [AW-1:0] rom_addr, ram_addr;
  logic [7:0]    rom_q, ram_d;
  logic [31:0]   hdr_offset, hdr_width, hdr_height;

  logic [7:0] rom_mem [0:N-1];
  logic [7:0] ram_shadow [int];
  int tests = 0;
  int fails = 0;
  int nwr;

  bmp_load_ctrl #(.BYTE_WIDTH(8), .ADDR_WIDTH(AW), .TOTAL_SIZE(N), .RAM_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .rom_valid(rom_valid), .rom_addr(rom_addr), .rom_q(rom_q),
    .ram_valid(ram_valid), .ram_addr(ram_addr), .ram_d(ram_d),
    .busy(busy), .done(done), .err_sig(err_sig), .err_size(err_size),
    .hdr_offset(hdr_offset), .hdr_width(hdr_width), .hdr_height(hdr_height)
  );

  always #5 clk = ~clk;

  // Registered ROM model
  always @(posedge clk) rom_q <= (int'(rom_addr) < N) ? rom_mem[int'(rom_addr)] : 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] le32(input int k);
    return {rom_mem[k+3], rom_mem[k+2], rom_mem[k+1], rom_mem[k]};
  endfunction

  task automatic build_image(input logic [7:0] b1, input logic [31:0] sz);
    logic [7:0] px [8];
    px = '{8'h10, 8'hA5, 8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E, 8'h5A};
    for (int i = 0; i < N; i++) rom_mem[i] = 8'((i * 7 + 3) & 255);
    rom_mem[0] = 8'h42;
    rom_mem[1] = b1;
    {rom_mem[5],  rom_mem[4],  rom_mem[3],  rom_mem[2]}  = sz;
    {rom_mem[13], rom_mem[12], rom_mem[11], rom_mem[10]} = 32'd54;
    {rom_mem[21], rom_mem[20], rom_mem[19], rom_mem[18]} = 32'd2;
    {rom_mem[25], rom_mem[24], rom_mem[23], rom_mem[22]} = 32'd1;
    for (int i = 0; i < 8; i++) rom_mem[54 + i] = px[i];
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rom_valid"}, 32'(rom_valid), 0);
    chk({tag, " rom_addr"},  32'(rom_addr), 0);
    chk({tag, " ram_valid"}, 32'(ram_valid), 0);
    chk({tag, " ram_addr"},  32'(ram_addr), 0);
    chk({tag, " ram_d"},     32'(ram_d), 0);
    chk({tag, " busy"},      32'(busy), 0);
    chk({tag, " done"},      32'(done), 0);
    chk({tag, " err_sig"},   32'(err_sig), 0);
    chk({tag, " err_size"},  32'(err_size), 0);
    chk({tag, " hdr_offset"}, hdr_offset, 32'hFFFF_FFFF);
    chk({tag, " hdr_width"},  hdr_width, 0);
    chk({tag, " hdr_height"}, hdr_height, 0);
  endtask

  // Model: from the ROM image alone, derive which cycle (counted from the
  // start pulse) must show each read, write, done and busy, then compare.
  task automatic run_copy(input logic m, input bit poke);
    int e, k;
    logic [31:0] off;
    bit rv, wv, dn, bz;
    logic [7:0] exp_d;
    e = (rom_mem[0] != 8'h42) ? 0 : (rom_mem[1] != 8'h4D) ? 1 : -1;
    off = le32(10);
    nwr = 0;
    ram_shadow.delete();
    @(negedge clk); start = 1'b1; mode = m;
    @(negedge clk); start = 1'b0; mode = ~m; // later mode changes must not matter
    for (int t = 1; t <= N + 4; t++) begin
      if (e < 0) begin
        rv = (t <= N); wv = (t >= 2 && t <= N + 1); dn = (t == N + 2); bz = (t <= N + 2);
      end else begin
        rv = (t <= e + 2); wv = (t >= 2 && t < e + 2); dn = (t == e + 3); bz = (t <= e + 3);
      end
      chk($sformatf("t%0d rom_valid", t), 32'(rom_valid), 32'(rv));
      chk($sformatf("t%0d ram_valid", t), 32'(ram_valid), 32'(wv));
      chk($sformatf("t%0d done", t), 32'(done), 32'(dn));
      chk($sformatf("t%0d busy", t), 32'(busy), 32'(bz));
      if (rv) chk($sformatf("t%0d rom_addr", t), 32'(rom_addr), 32'(t - 1));
      if (wv) begin
        k = t - 2;
        exp_d = (m && k >= 54 && k >= int'(off)) ? ~rom_mem[k] : rom_mem[k];
        chk($sformatf("t%0d ram_addr", t), 32'(ram_addr), 32'((k + BASE) & 32'hF_FFFF));
        chk($sformatf("t%0d ram_d", t), 32'(ram_d), 32'(exp_d));
      end
      if (e < 0 && t == 17) chk("wrap byte15 addr", 32'(ram_addr), 32'h000F_FFFF);
      if (e < 0 && t == 18) chk("wrap byte16 addr", 32'(ram_addr), 32'h0);
      if (dn) begin
        chk("done err_sig", 32'(err_sig), 32'(e >= 0));
        chk("done err_size", 32'(err_size), 32'(e < 0 && le32(2) != 32'(N)));
        if (e < 0) begin
          chk("done hdr_offset", hdr_offset, le32(10));
          chk("done hdr_width", hdr_width, le32(18));
          chk("done hdr_height", hdr_height, le32(22));
        end
      end
      if (ram_valid) begin
        ram_shadow[int'(ram_addr)] = ram_d;
        nwr++;
      end
      start = (poke && (t == 10 || t == N + 2)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    build_image(8'h4D, 32'd62);
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // mode 0, with stray start pulses while busy
    run_copy(1'b0, 1'b1);
    chk("m0 writes", 32'(nwr), 32'd62);
    chk("m0 width literal", hdr_width, 32'd2);
    chk("m0 height literal", hdr_height, 32'd1);
    chk("m0 offset literal", hdr_offset, 32'd54);
    chk("m0 err_sig held", 32'(err_sig), 0);
    for (int k = 0; k < N; k++)
      chk($sformatf("m0 ram[%0d]", k), 32'(ram_shadow[int'((k + BASE) & 32'hF_FFFF)]), 32'(rom_mem[k]));
    chk("m0 pixel literal", 32'(ram_shadow[32'h26]), 32'h10);

    // mode 1 inversion
    run_copy(1'b1, 1'b0);
    chk("m1 pixel literal", 32'(ram_shadow[32'h26]), 32'hEF);
    chk("m1 hdr byte0 literal", 32'(ram_shadow[32'hFFFF0]), 32'h42);
    chk("m1 hdr byte10 literal", 32'(ram_shadow[32'hFFFFA]), 32'd54);

    // bad signature byte 1
    build_image(8'h4E, 32'd62);
    run_copy(1'b0, 1'b0);
    chk("sig writes literal", 32'(nwr), 32'd1);
    chk("sig err_sig literal", 32'(err_sig), 1);
    chk("sig addr0 literal", 32'(ram_shadow.exists(32'hFFFF0)), 1);

    // size mismatch: flagged but full copy
    build_image(8'h4D, 32'd100);
    run_copy(1'b0, 1'b0);
    chk("size err literal", 32'(err_size), 1);
    chk("size writes literal", 32'(nwr), 32'd62);

    // reset mid-copy, then a normal copy
    build_image(8'h4D, 32'd62);
    @(negedge clk); start = 1'b1; mode = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("midrst");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_copy(1'b1, 1'b0);
    chk("post-rst writes", 32'(nwr), 32'd62);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bmp_load_ctrl.md
Name: bmp_load_ctrl

Overview:
- Parametrised controller that streams a BMP image byte-by-byte from a registered ROM into a RAM.
- Parses the BMP header on the fly and optionally inverts pixel bytes during the copy.
- Sits between BMP_ROM and BMP_RAM in the image pipeline and supersedes LOAD_BMP.
- Adds signature/size checking, header field outputs, a configurable RAM base and a pixel-inversion mode.

Parameters:
- BYTE_WIDTH, 8, data byte width.
- ADDR_WIDTH, 20, ROM/RAM address width.
- TOTAL_SIZE, 786486, bytes to copy (complete BMP file).
- RAM_BASE, 0, RAM address of byte 0; RAM address = ROM address + RAM_BASE, mod 2^ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; starts a copy when idle, ignored otherwise.
- mode  in  1  0 = raw copy; 1 = invert bytes at index >= hdr_offset. Sampled on start.
- rom_valid  out  1  ROM read enable.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_q  in  BYTE_WIDTH  ROM data, valid one cycle after rom_valid.
- ram_valid  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM write address.
- ram_d  out  BYTE_WIDTH  RAM write data.
- busy  out  1  high from the cycle after start until the done cycle, inclusive.
- done  out  1  one-cycle completion pulse.
- err_sig  out  1  sticky: bytes 0/1 were not 'B' (0x42) / 'M' (0x4D).
- err_size  out  1  sticky: header file size (bytes 2-5, little endian) != TOTAL_SIZE.
- hdr_offset  out  32  pixel data offset (bytes 10-13, LE).
- hdr_width  out  32  image width (bytes 18-21, LE).
- hdr_height  out  32  image height (bytes 22-25, LE).

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs 0.
  - hdr_offset resets to 0xFFFFFFFF so no inversion can occur before the offset is parsed.
- FSM states: IDLE, READ, DRAIN, DONE, ERR.
- IDLE:
  - On start, latch mode, clear err_sig, err_size and the header fields, then go to READ.
- READ:
  - rom_valid=1 every cycle; rom_addr counts 0..TOTAL_SIZE-1.
  - After issuing address TOTAL_SIZE-1, go to DRAIN.
- Data return (one cycle after each read):
  - ram_valid=1, ram_addr = issued address + RAM_BASE.
  - ram_d = rom_q, or ~rom_q when mode=1 and index >= hdr_offset.
- Throughput and latency:
  - 1 byte/cycle, no bubbles.
  - First RAM write occurs 2 cycles after start.
- DRAIN:
  - Last write completes, then go to DONE.
- DONE:
  - done=1 for one cycle, busy still 1, then go to IDLE.
  - Total: start at cycle 0 -> done at cycle TOTAL_SIZE+2.
- Header capture:
  - Fields are assembled as their bytes return.
  - Comparisons use fully assembled fields only.
  - Header bytes (index < 54) are never inverted.
- Signature check:
  - Performed on return of byte 0 and byte 1.
  - On mismatch: the byte is not written, err_sig=1, the in-flight read is discarded, no further writes, go to ERR.
- ERR:
  - done=1 for one cycle, then go to IDLE.
- err_size:
  - Flagged on return of byte 5 and does not abort; the copy continues for TOTAL_SIZE bytes.
- start while busy: ignored.
- rst mid-copy: immediate abort, all outputs to reset values. RAM contents undefined, no done pulse.
- TOTAL_SIZE < 26: elaboration error ($error in generate).

Optional Feature:
- BMP_CHECKSUM_EN defined:
  - Adds output checksum [15:0].
  - Cleared on start; mod-2^16 sum of every ram_d actually written.
  - Valid while done=1 and held until the next start.
- Not defined: port absent, no adder logic.

Test Plan:
- 54-byte header + 8 pixel bytes (TOTAL_SIZE=62, size field 62, offset 54, width 2, height 1), mode=0 -> 62 writes, RAM identical to ROM, done at cycle 64, err flags 0, hdr_width=2, hdr_height=1.
- Same image, mode=1, pixel byte 0x10 -> RAM pixel byte 0xEF, header bytes unchanged.
- Byte 1 = 0x4E -> exactly one write (addr 0), err_sig=1, done pulse, no further ram_valid.
- Size field 100 with TOTAL_SIZE=62 -> err_size=1, full 62-byte copy still performed.
- RAM_BASE=0xFFFF0, ADDR_WIDTH=20 -> ram_addr wraps 0xFFFFF -> 0x00000 at byte 16.
- rst pulse at cycle 20 of a copy -> all outputs 0 next edge; a later start completes normally. Also: start asserted while busy -> no effect.
